instruction_fetch: RTL
======================

# instruction_fetch

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of instruction decode. It owns the PC and issues word fetches to instruction memory over a request/response handshake, keeping at most one request outstanding. It absorbs stalls in a one-entry skid buffer, discards responses that are stale after a branch redirect, and drives the IF/ID pipeline register consumed by decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word inserted on a bubble or flush (addi x0,x0,0)

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low
- stall  in  1  hazard hold: IF/ID keeps its value, PC does not advance
- flush  in  1  IF/ID loads NOP, valid=0
- pc_src  in  1  branch/jump redirect taken
- branch_target  in  32  redirect address; bits[1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to PC
- imem_ready  in  1  request accepted when imem_req & imem_ready
- imem_rvalid  in  1  response valid, earliest 1 cycle after accept
- imem_rdata  in  32  response instruction
- if_id_instruction_out  out  32  IF/ID instruction
- if_id_npc_out  out  32  IF/ID PC+4
- if_id_pc_out  out  32  IF/ID PC
- if_id_valid_out  out  1  IF/ID holds a real instruction

## Operation
- FSM states:
  - IDLE: imem_req=1 when the skid buffer is empty and pc_src=0. req&ready → WAIT, latch fetch_pc=PC.
  - WAIT: imem_req=0.
    - rvalid & pc_src: discard the response; PC←branch_target; → IDLE.
    - rvalid alone: PC←PC+4; → IDLE. If stall=1 and flush=0, the response goes into the skid buffer; otherwise it goes to IF/ID per the priority list below.
    - pc_src without rvalid: PC←branch_target; → DROP.
  - DROP: on rvalid, discard the response; → IDLE.
- pc_src in IDLE: PC←branch_target; no request is issued that cycle.
- imem_rvalid in IDLE is ignored.
- IF/ID update priority, evaluated every cycle:
  1. reset
  2. flush | pc_src: NOP, valid=0; skid cleared
  3. stall: hold
  4. skid valid: load skid; clear skid
  5. WAIT & rvalid: load response, npc=fetch_pc+4, pc=fetch_pc, valid=1
  6. otherwise: NOP, valid=0
- Skid buffer: one entry holding {instr, fetch_pc}. While it is full, no new request is issued.
- Arithmetic: PC+4 is modulo 2^32; wrap from 0xFFFF_FFFC to 0 is silent.
- Reset values:
  - state=IDLE, PC=RESET_PC, skid empty
  - if_id_instruction_out=NOP_INSTR, if_id_npc_out=0, if_id_pc_out=0, if_id_valid_out=0
  - imem_req=0 while reset is low
- Reset mid-operation: an outstanding request is abandoned. A response arriving after reset lands in IDLE and is ignored.

## Timing
- Accept at cycle N, rvalid at N+k (k≥1). IF/ID is valid at N+k+1. The next request is issued at N+k+1.
- Peak throughput: one instruction per 2 cycles (one outstanding request).
- pc_src at cycle N: imem_addr=branch_target at N+1 (from IDLE or WAIT+rvalid); IF/ID is a bubble at N+1.
- stall is sampled each cycle. Release at N gives IF/ID the skid contents at N+1.

## Configuration
- IF_PERF_CNT_EN:
  - Defined: adds output ports perf_fetched (32) and perf_bubbles (32).
    - perf_fetched increments on each IF/ID load with valid=1.
    - perf_bubbles increments on each non-stall cycle where IF/ID loads NOP.
    - Both reset to 0 and wrap modulo 2^32.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package holds NOP_INSTR, the default RESET_PC, and the FSM state enum {IDLE, WAIT, DROP}.
- One sub-module, if_id: the IF/ID pipeline register with stall/flush inputs, mirroring id_ex. The FSM, PC and skid buffer stay in instruction_fetch.

## Test plan
- Reset release, ready=1, rvalid 1 cycle after accept with 0x00500093 → first imem_addr=0x0; two cycles after accept, IF/ID instr=0x00500093, npc=0x4, valid=1; next imem_addr=0x4.
- rvalid with 0x00A00113 while stall=1 → IF/ID unchanged, imem_req=0; stall drops → next cycle IF/ID instr=0x00A00113, valid=1.
- pc_src=1, target=0x82 in WAIT before rvalid → later response discarded; next imem_addr=0x80; IF/ID NOP, valid=0.
- pc_src=1 coincident with rvalid → response dropped, next imem_addr=target, skid empty.
- reset low during WAIT, stale rvalid after reset → state IDLE, PC=RESET_PC, response ignored, IF/ID valid=0.
- IF_PERF_CNT_EN defined, 3 fetches with one stall cycle → perf_fetched=3; perf_bubbles equals the non-stall NOP cycles counted by the bench.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: the reset PC, the
// bubble instruction word and the fetch FSM state encoding.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if_id.sv
// IF/ID pipeline register. Priority: reset, flush, stall (hold), load,
// otherwise a bubble. Bubbles carry NOP_INSTR with pc/npc cleared.
import instruction_fetch_pkg::*;

module instruction_fetch_if_id (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] npc_in,
  output logic [31:0] instruction,
  output logic [31:0] npc,
  output logic [31:0] pc,
  output logic        valid
);

  // Register update in decreasing priority; stall leaves everything as is.
  always_ff @(posedge clock) begin
    if (!reset || flush || (!stall && !load)) begin
      instruction <= NOP_INSTR;
      npc         <= 32'h0;
      pc          <= 32'h0;
      valid       <= 1'b0;
    end else if (!stall) begin
      instruction <= instr_in;
      npc         <= npc_in;
      pc          <= pc_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// parks a response that arrives during a stall in a one-entry skid buffer,
// and drops responses made stale by a redirect.
// Optional feature macro IF_PERF_CNT_EN adds perf_fetched / perf_bubbles.
//
// state | meaning
// IDLE  | may issue a fetch for PC (skid empty, no redirect this cycle)
// WAIT  | request accepted, waiting for its response
// DROP  | redirected while waiting; the pending response is discarded
import instruction_fetch_pkg::*;

module instruction_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instruction_out,
  output logic [31:0] if_id_npc_out,
  output logic [31:0] if_id_pc_out,
  output logic        if_id_valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  fetch_pc;
  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  logic [31:0]  target;
  logic         wait_rvalid;
  logic         ifid_flush;
  logic         ifid_load;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;

  // Redirect address is word aligned; the response only counts while in WAIT.
  always_comb begin
    target      = branch_target & ~32'h3;
    wait_rvalid = (state == WAIT) && imem_rvalid;
    ifid_flush  = flush || pc_src;
    ifid_load   = skid_valid || wait_rvalid;
    ifid_instr  = skid_valid ? skid_instr : imem_rdata;
    ifid_pc     = skid_valid ? skid_pc    : fetch_pc;
  end

  // Request depends on same-cycle pc_src so a redirect suppresses it at once.
  assign imem_req  = reset && (state == IDLE) && !skid_valid && !pc_src;
  assign imem_addr = pc;

  // Fetch FSM and PC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (pc_src) begin
            pc <= target;
          end else if (imem_req && imem_ready) begin
            fetch_pc <= pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            pc    <= pc_src ? target : pc + 32'd4;
            state <= IDLE;
          end else if (pc_src) begin
            pc    <= target;
            state <= DROP;
          end
        end
        DROP: begin
          // A further redirect while draining still moves the PC.
          if (pc_src) pc <= target;
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: captures a response that lands while decode is stalled.
  always_ff @(posedge clock) begin
    if (!reset || ifid_flush) begin
      skid_valid <= 1'b0;
    end else if (stall) begin
      if (wait_rvalid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= fetch_pc;
      end
    end else begin
      skid_valid <= 1'b0;
    end
  end

  instruction_fetch_if_id u_if_id (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush       (ifid_flush),
    .load        (ifid_load),
    .instr_in    (ifid_instr),
    .pc_in       (ifid_pc),
    .npc_in      (ifid_pc + 32'd4),
    .instruction (if_id_instruction_out),
    .npc         (if_id_npc_out),
    .pc          (if_id_pc_out),
    .valid       (if_id_valid_out)
  );

`ifdef IF_PERF_CNT_EN
  logic ifid_load_real;
  assign ifid_load_real = !ifid_flush && !stall && ifid_load;

  // Count valid IF/ID loads and non-stall cycles that insert a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_fetched <= 32'h0;
      perf_bubbles <= 32'h0;
    end else begin
      if (ifid_load_real) perf_fetched <= perf_fetched + 32'd1;
      if (!stall && !ifid_load_real) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
